// File: rtl/lpif_online_seq_pkg.sv
// Shared definitions for the LPIF online sequencer.
//   state_t  : sequencer state encoding (3-bit, visible in the debug word)
//   CNT_W    : width of the per-state cycle counter
//   ERR_W    : width of the error-entry counter
package lpif_online_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_PHY  = 3'd1,
    ST_TX_SETTLE = 3'd2,
    ST_RX_ALIGN  = 3'd3,
    ST_UP        = 3'd4,
    ST_ERR       = 3'd5
  } state_t;

  localparam int CNT_W = 16;
  localparam int ERR_W = 8;

endpackage

// File: rtl/lpif_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   rst_n : synchronous active-low reset, forces cnt to 0
//   clr   : synchronous clear (wins over inc)
//   inc   : increment request; the count sticks at all-ones
//   cnt   : current count
module lpif_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lpif_online_seq.sv
// LPIF online sequencer: brings the TX then RX datapath online once every
// PHY channel reports ready, waits for RX alignment and declares the link up.
// Any ready drop while online, or a wait timeout, parks the FSM in ERR until
// link_enable is withdrawn.
//   clk_wr           : single clock
//   rst_wr_n         : synchronous active-low reset
//   link_enable      : 1 requests bring-up, 0 requests teardown (top priority)
//   phy_tx_ready     : per-channel PHY TX ready
//   phy_rx_ready     : per-channel PHY RX ready
//   rx_align_ok      : datapath alignment achieved
//   settle_value     : TX settle cycles before RX enable (sampled live)
//   timeout_value    : wait timeout in cycles, 0 disables (sampled live)
//   tx_online        : datapath TX enable
//   rx_online        : datapath RX enable
//   link_up          : link operational
//   link_err         : sequencing failure
//   seq_debug_status : {err_cnt, 8'h0, tx_ready[3:0], rx_ready[3:0], 5'h0, state}
module lpif_online_seq
  import lpif_online_seq_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk_wr,
  input  logic              rst_wr_n,
  input  logic              link_enable,
  input  logic [NUM_CH-1:0] phy_tx_ready,
  input  logic [NUM_CH-1:0] phy_rx_ready,
  input  logic              rx_align_ok,
  input  logic [15:0]       settle_value,
  input  logic [15:0]       timeout_value,
  output logic              tx_online,
  output logic              rx_online,
  output logic              link_up,
  output logic              link_err,
  output logic [31:0]       seq_debug_status
);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [ERR_W-1:0]  err_cnt;
  logic              all_ready;
  logic              tmo_hit;
  logic              state_chg;
  logic              err_entry;
  logic [3:0]        tx_rdy4;
  logic [3:0]        rx_rdy4;

  assign all_ready = (&phy_tx_ready) & (&phy_rx_ready);
  // Fires on the last allowed cycle so the ERR transition lands exactly
  // timeout_value cycles after entering the waiting state.
  assign tmo_hit   = (timeout_value != 16'd0) && (cyc_cnt == timeout_value - 16'd1);
  assign state_chg = (state_nxt != state);
  assign err_entry = (state_nxt == ST_ERR) && (state != ST_ERR);

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!link_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      state_nxt = ST_WAIT_PHY;
        ST_WAIT_PHY: begin
          if (all_ready)    state_nxt = ST_TX_SETTLE;
          else if (tmo_hit) state_nxt = ST_ERR;
        end
        ST_TX_SETTLE: begin
          if (!all_ready)                  state_nxt = ST_ERR;
          else if (cyc_cnt >= settle_value) state_nxt = ST_RX_ALIGN;
        end
        ST_RX_ALIGN: begin
          if (!all_ready)       state_nxt = ST_ERR;
          else if (rx_align_ok) state_nxt = ST_UP;
          else if (tmo_hit)     state_nxt = ST_ERR;
        end
        ST_UP: begin
          if (!all_ready) state_nxt = ST_ERR;
        end
        ST_ERR:       state_nxt = ST_ERR;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  lpif_sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk_wr),
    .rst_n (rst_wr_n),
    .clr   (state_chg),
    .inc   (1'b1),
    .cnt   (cyc_cnt)
  );

  lpif_sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk_wr),
    .rst_n (rst_wr_n),
    .clr   (1'b0),
    .inc   (err_entry),
    .cnt   (err_cnt)
  );

  always_comb begin
    tx_online = 1'b0;
    rx_online = 1'b0;
    link_up   = 1'b0;
    link_err  = 1'b0;
    case (state)
      ST_TX_SETTLE: tx_online = 1'b1;
      ST_RX_ALIGN: begin
        tx_online = 1'b1;
        rx_online = 1'b1;
      end
      ST_UP: begin
        tx_online = 1'b1;
        rx_online = 1'b1;
        link_up   = 1'b1;
      end
      ST_ERR:       link_err = 1'b1;
      default:      ;
    endcase
  end

  always_comb begin
    tx_rdy4               = 4'h0;
    rx_rdy4               = 4'h0;
    tx_rdy4[NUM_CH-1:0]   = phy_tx_ready;
    rx_rdy4[NUM_CH-1:0]   = phy_rx_ready;
  end

  assign seq_debug_status = {err_cnt, 8'h00, tx_rdy4, rx_rdy4, 5'h00, state};

endmodule
